// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/ready bus between the fetch stage (master) and memory (slave).
interface if_fetch_stage_if #(
  parameter int DATA_W = 16
) ();
  logic              imem_req;
  logic [DATA_W-1:0] imem_addr;
  logic              imem_ready;
  logic [DATA_W-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem handshake, holds one instruction for IF/ID.
// Optional perf counters (fetch_count/stall_count) are built when IF_PERF_CNT_EN is defined.
module if_fetch_stage #(
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              IFID_write,
  input  logic              branch_taken,
  input  logic [DATA_W-1:0] branch_target,
  if_fetch_stage_if.master  imem,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] PC_Plus1,
  output logic [DATA_W-1:0] Inst,
  output logic              valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0]       fetch_count,
  output logic [15:0]       stall_count
`endif
);

  typedef enum logic {BOOT, FETCH} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] buf_pc_q, buf_pc_d;
  logic [DATA_W-1:0] buf_pp1_q, buf_pp1_d;
  logic [DATA_W-1:0] buf_inst_q, buf_inst_d;
  logic              valid_q, valid_d;
  logic              accept, can_load, req, load;

  assign accept   = valid_q & ~IFID_write;
  assign can_load = ~valid_q | ~IFID_write;
  assign load     = req & imem.imem_ready;

  always_comb begin
    state_d    = FETCH;
    req        = 1'b0;
    pc_d       = pc_q;
    valid_d    = valid_q;
    buf_pc_d   = buf_pc_q;
    buf_pp1_d  = buf_pp1_q;
    buf_inst_d = buf_inst_q;
    if (state_q == FETCH) req = can_load & ~branch_taken;
    // Redirect flushes the buffer even under stall; req is already low so no load can race it.
    if (branch_taken) begin
      pc_d = branch_target;
      if (state_q == FETCH) valid_d = 1'b0;
    end else if (load) begin
      pc_d       = pc_q + 1'b1;
      buf_pc_d   = pc_q;
      buf_pp1_d  = pc_q + 1'b1;
      buf_inst_d = imem.imem_rdata;
      valid_d    = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      buf_pc_q   <= '0;
      buf_pp1_q  <= '0;
      buf_inst_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_pc_q   <= buf_pc_d;
      buf_pp1_q  <= buf_pp1_d;
      buf_inst_q <= buf_inst_d;
      valid_q    <= valid_d;
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;
  assign PC             = buf_pc_q;
  assign PC_Plus1       = buf_pp1_q;
  assign Inst           = buf_inst_q;
  assign valid          = valid_q;

`ifdef IF_PERF_CNT_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (load && fetch_cnt_q != 16'hFFFF) fetch_cnt_d = fetch_cnt_q + 16'd1;
    if (state_q == FETCH && valid_q && IFID_write && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus randomized traffic vs a buffer-level model.
module tb_if_fetch_stage;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        IFID_write = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = '0;
  logic        ready = 1'b0;
  logic [15:0] PC0, PP0, I0, PC1, PP1, I1;
  logic        V0, V1;
`ifdef IF_PERF_CNT_EN
  logic [15:0] fc0, sc0, fc1, sc1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  if_fetch_stage_if #(.DATA_W(16)) bus0 ();
  if_fetch_stage_if #(.DATA_W(16)) bus1 ();

  // Memory returns a recognisable function of the address.
  assign bus0.imem_ready = ready;
  assign bus0.imem_rdata = bus0.imem_addr ^ 16'hA5A5;
  assign bus1.imem_ready = ready;
  assign bus1.imem_rdata = bus1.imem_addr ^ 16'hA5A5;

  if_fetch_stage #(.DATA_W(16), .RESET_PC(16'h0000)) dut0 (
    .clock(clock), .reset(reset), .IFID_write(IFID_write), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem(bus0.master),
    .PC(PC0), .PC_Plus1(PP0), .Inst(I0), .valid(V0)
`ifdef IF_PERF_CNT_EN
    , .fetch_count(fc0), .stall_count(sc0)
`endif
  );

  if_fetch_stage #(.DATA_W(16), .RESET_PC(16'hFFFF)) dut1 (
    .clock(clock), .reset(reset), .IFID_write(IFID_write), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem(bus1.master),
    .PC(PC1), .PC_Plus1(PP1), .Inst(I1), .valid(V1)
`ifdef IF_PERF_CNT_EN
    , .fetch_count(fc1), .stall_count(sc1)
`endif
  );

  // Reference model: a PC, a one-slot buffer, and a "just booted" flag.
  logic        m_boot = 1'b1;
  logic [15:0] m_pc = '0, m_bpc = '0, m_pp1 = '0, m_inst = '0;
  logic        m_vld = 1'b0;
  logic [15:0] m_fc = '0, m_sc = '0;
  logic        obs_req, exp_req;
  logic [15:0] obs_addr, exp_addr;

  task automatic tick(input logic r, input logic w, input logic b, input logic [15:0] t,
                      input logic rd);
    @(negedge clock);
    reset = r; IFID_write = w; branch_taken = b; branch_target = t; ready = rd;
    #1;
    obs_req  = bus0.imem_req;
    obs_addr = bus0.imem_addr;
    exp_addr = m_pc;
    exp_req  = !m_boot && !b && (!m_vld || !w);
    @(posedge clock);
    if (r) begin
      m_boot = 1'b1; m_pc = 16'h0000; m_vld = 1'b0;
      m_bpc = '0; m_pp1 = '0; m_inst = '0; m_fc = '0; m_sc = '0;
    end else begin
      if (!m_boot && m_vld && w && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
      if (b) begin
        m_pc = t;
        m_vld = 1'b0;
      end else if (exp_req && rd) begin
        m_bpc = m_pc; m_pp1 = m_pc + 16'd1; m_inst = m_pc ^ 16'hA5A5; m_vld = 1'b1;
        m_pc = m_pc + 16'd1;
        if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
      end else if (m_vld && !w) begin
        m_vld = 1'b0;
      end
      m_boot = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset;
    tick(1, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 1);
    total++;
    if (V0 !== 1'b0 || PC0 !== 16'h0 || PP0 !== 16'h0 || I0 !== 16'h0) begin
      bad++;
      $display("FAIL reset_state: got v=%b pc=%h pp1=%h inst=%h, want 0/0/0/0", V0, PC0, PP0, I0);
    end
    tick(0, 0, 0, 0, 1);
    total++;
    if (obs_req !== 1'b0) begin
      bad++; $display("FAIL boot_req: got %b want 0", obs_req);
    end
  endtask

  task automatic test_stream;
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 0, 1);
      total++;
      if (V0 !== 1'b1 || PC0 !== 16'(i) || PP0 !== 16'(i + 1) || I0 !== (16'(i) ^ 16'hA5A5)) begin
        bad++;
        $display("FAIL stream[%0d]: got v=%b pc=%h pp1=%h inst=%h, want 1/%h/%h/%h",
                 i, V0, PC0, PP0, I0, 16'(i), 16'(i + 1), 16'(i) ^ 16'hA5A5);
      end
    end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 0, 0, 1);
      total++;
      if (obs_req !== 1'b0 || V0 !== 1'b1 || PC0 !== 16'd3 || I0 !== (16'd3 ^ 16'hA5A5)) begin
        bad++;
        $display("FAIL stall[%0d]: got req=%b v=%b pc=%h inst=%h, want 0/1/0003/%h",
                 i, obs_req, V0, PC0, I0, 16'd3 ^ 16'hA5A5);
      end
    end
    tick(0, 0, 0, 0, 1);
    total++;
    if (V0 !== 1'b1 || PC0 !== 16'd4) begin
      bad++; $display("FAIL stall_release: got v=%b pc=%h want 1/0004", V0, PC0);
    end
  endtask

  task automatic test_wait;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0, 0);
      total++;
      if (obs_req !== 1'b1 || obs_addr !== 16'd5 || V0 !== 1'b0) begin
        bad++;
        $display("FAIL wait[%0d]: got req=%b addr=%h v=%b want 1/0005/0", i, obs_req, obs_addr, V0);
      end
    end
    tick(0, 0, 0, 0, 1);
    total++;
    if (V0 !== 1'b1 || PC0 !== 16'd5 || I0 !== (16'd5 ^ 16'hA5A5)) begin
      bad++; $display("FAIL wait_done: got v=%b pc=%h inst=%h want 1/0005", V0, PC0, I0);
    end
  endtask

  task automatic test_redirect;
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    total++;
    if (PC0 !== 16'd7 || V0 !== 1'b1) begin
      bad++; $display("FAIL redir_setup: got pc=%h v=%b want 0007/1", PC0, V0);
    end
    tick(0, 1, 1, 16'h0040, 1);
    total++;
    if (obs_req !== 1'b0 || V0 !== 1'b0) begin
      bad++; $display("FAIL redir_flush: got req=%b v=%b want 0/0", obs_req, V0);
    end
    tick(0, 0, 0, 0, 1);
    total++;
    if (obs_addr !== 16'h0040 || obs_req !== 1'b1 || V0 !== 1'b1 || PC0 !== 16'h0040) begin
      bad++;
      $display("FAIL redir_target: got addr=%h req=%b v=%b pc=%h want 0040/1/1/0040",
               obs_addr, obs_req, V0, PC0);
    end
  endtask

  task automatic test_wrap;
    tick(1, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    total++;
    if (V1 !== 1'b1 || PC1 !== 16'hFFFF || PP1 !== 16'h0000) begin
      bad++; $display("FAIL wrap_first: got v=%b pc=%h pp1=%h want 1/ffff/0000", V1, PC1, PP1);
    end
    tick(0, 0, 0, 0, 1);
    total++;
    if (V1 !== 1'b1 || PC1 !== 16'h0000 || PP1 !== 16'h0001) begin
      bad++; $display("FAIL wrap_next: got v=%b pc=%h pp1=%h want 1/0000/0001", V1, PC1, PP1);
    end
  endtask

  task automatic test_random;
    logic r, w, b, rd;
    logic [15:0] t;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 59) == 0);
      w  = ($urandom_range(0, 2) == 0);
      b  = ($urandom_range(0, 7) == 0);
      rd = ($urandom_range(0, 2) != 0);
      t  = 16'($urandom);
      tick(r, w, b, t, rd);
      total++;
      if (obs_req !== exp_req || obs_addr !== exp_addr) begin
        bad++;
        $display("FAIL rand_req[%0d]: got req=%b addr=%h want %b/%h", i, obs_req, obs_addr, exp_req, exp_addr);
      end
      total++;
      if (V0 !== m_vld || PC0 !== m_bpc || PP0 !== m_pp1 || I0 !== m_inst) begin
        bad++;
        $display("FAIL rand_buf[%0d]: got v=%b pc=%h pp1=%h inst=%h want %b/%h/%h/%h",
                 i, V0, PC0, PP0, I0, m_vld, m_bpc, m_pp1, m_inst);
      end
`ifdef IF_PERF_CNT_EN
      total++;
      if (fc0 !== m_fc || sc0 !== m_sc) begin
        bad++; $display("FAIL rand_cnt[%0d]: got f=%0d s=%0d want %0d/%0d", i, fc0, sc0, m_fc, m_sc);
      end
`endif
    end
  endtask

  task automatic test_reset_mid;
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    tick(0, 1, 0, 0, 0);
    total++;
    if (V0 !== 1'b1) begin
      bad++; $display("FAIL rmid_setup: got v=%b want 1", V0);
    end
    tick(1, 1, 0, 0, 0);
    total++;
    if (V0 !== 1'b0 || PC0 !== 16'h0 || PP0 !== 16'h0 || I0 !== 16'h0) begin
      bad++; $display("FAIL rmid_state: got v=%b pc=%h pp1=%h inst=%h want 0/0/0/0", V0, PC0, PP0, I0);
    end
`ifdef IF_PERF_CNT_EN
    total++;
    if (fc0 !== 16'h0 || sc0 !== 16'h0) begin
      bad++; $display("FAIL rmid_cnt: got f=%0d s=%0d want 0/0", fc0, sc0);
    end
`endif
    tick(0, 1, 0, 0, 1);
    total++;
    if (obs_req !== 1'b0 || obs_addr !== 16'h0000) begin
      bad++; $display("FAIL rmid_boot: got req=%b addr=%h want 0/0000", obs_req, obs_addr);
    end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_wait;
    test_redirect;
    test_wrap;
    test_random;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
